fetch_prefetch_unit: RTL

Parametrised successor to the single-cycle fetch stage: a pipelined instruction fetch unit with a prefetch FIFO and multiple outstanding requests to a variable-latency instruction memory. It sits between instruction memory and the decode stage, and tags each instruction with its word PC. Redirects from the memory stage (`pc_jmp` / `pc_target_address`) flush all queued and in-flight instructions. It replaces the assumption of a one-cycle `inst_in` response.

---
 rtl/fetch_prefetch_unit.sv | 93 +++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: pipelined instruction fetch with prefetch FIFO and multiple outstanding imem requests
module fetch_prefetch_unit #(
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [29:0] RESET_PC = 30'h0,
  parameter bit BYTE_SWAP = 1'b1
) (
  input  logic                   clk,
  input  logic                   async_rst_n,
  input  logic                   clk_en,
  input  logic                   redirect,
  input  logic [29:0]            redirect_addr,
  output logic                   imem_req,
  output logic [29:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  output logic [31:0]            out_inst,
  output logic [29:0]            out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int CW1 = CW + 1;
  logic [29:0]   r_fetch_pc, r_rsp_pc;
  logic [CW-1:0] r_outstanding, r_discard, r_count;
  logic [AW-1:0] r_rd, r_wr;
  logic [31:0]   r_inst [DEPTH];
  logic [29:0]   r_pc [DEPTH];
  logic          w_issue, w_rsp, w_drop, w_push, w_pop, w_redir;
  logic [CW-1:0] w_out_next;
  logic [CW:0]   w_credit;
  logic [31:0]   w_head;
  // request/response/pop qualifiers; a response with nothing outstanding is ignored
  always_comb begin
    w_credit   = {1'b0, r_outstanding} + {1'b0, r_count};
    imem_req   = async_rst_n & clk_en & (r_outstanding < CW'(MAX_OUTSTANDING)) & (w_credit < CW1'(DEPTH));
    imem_addr  = r_fetch_pc;
    w_issue    = imem_req & imem_gnt;
    w_rsp      = imem_rvalid & (r_outstanding != '0);
    w_drop     = w_rsp & (r_discard != '0);
    w_push     = w_rsp & ~w_drop;
    w_redir    = redirect & clk_en;
    out_valid  = r_count != '0;
    w_pop      = clk_en & out_valid & out_ready;
    w_out_next = r_outstanding + CW'(w_issue) - CW'(w_rsp);
    w_head     = r_inst[r_rd];
    out_inst   = BYTE_SWAP ? {w_head[7:0], w_head[15:8], w_head[23:16], w_head[31:24]} : w_head;
    out_pc     = r_pc[r_rd];
    level      = r_count;
  end
  // PCs, credit counters and FIFO pointers; redirect flushes and counts in-flight words to drop
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_rd          <= '0;
      r_wr          <= '0;
    end else begin
      r_outstanding <= w_out_next;
      if (w_redir) begin
        r_fetch_pc <= redirect_addr;
        r_rsp_pc   <= redirect_addr;
        r_discard  <= w_out_next;
        r_count    <= '0;
        r_rd       <= '0;
        r_wr       <= '0;
      end else begin
        r_fetch_pc <= r_fetch_pc + 30'(w_issue);
        r_rsp_pc   <= r_rsp_pc + 30'(w_push);
        r_discard  <= r_discard - CW'(w_drop);
        r_count    <= r_count + CW'(w_push) - CW'(w_pop);
        r_rd       <= r_rd + AW'(w_pop);
        r_wr       <= r_wr + AW'(w_push);
      end
    end
  // FIFO storage of {inst, pc}; reset entries so the head shows reset values
  always_ff @(posedge clk or negedge async_rst_n)
    if (!async_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= RESET_PC;
      end
    end else if (w_push && !w_redir) begin
      r_inst[r_wr] <= imem_rdata;
      r_pc[r_wr]   <= r_rsp_pc;
    end
endmodule
